// File: rtl/rv_fetch_ctrl.sv
// Instruction fetch controller: single-outstanding bus master feeding a small decode buffer.
// Defining RV_FETCH_CTRL_SKID_EN selects a 2-entry buffer; otherwise the buffer holds 1 entry.
module rv_fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_redirect,
    input  logic [31:2] i_redirect_pc,
    input  logic        i_dec_ready,
    output logic        o_imem_req,
    output logic [31:2] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_err,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:2] o_inst_pc,
    output logic        o_inst_err,
    output logic        o_busy
);

`ifdef RV_FETCH_CTRL_SKID_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDrop, StHalt} state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:2] pc;
        logic        err;
    } entry_t;

    state_e      state_q;
    logic [31:2] fetch_pc_q;
    logic [31:2] inflight_pc_q;
    logic        req_q;
    logic        busy_q;
    entry_t      buf_q [DEPTH];
    entry_t      buf_d [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic fire;
    logic flush;
    logic push;
    logic pop;
    logic room;
    entry_t new_entry;

    always_comb begin
        fire      = req_q && i_imem_gnt;
        flush     = i_redirect && (state_q != StIdle);
        push      = (state_q == StWait) && i_imem_rvalid && !i_redirect;
        pop       = (cnt_q != '0) && i_dec_ready;
        new_entry = '{inst: i_imem_rdata, pc: inflight_pc_q, err: i_imem_err};
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            // Head always lives at index 0; a pop shifts the rest down.
            if (pop) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    buf_d[i] = buf_q[i+1];
                end
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (push) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (CNT_W'(i) == cnt_d) begin
                        buf_d[i] = new_entry;
                    end
                end
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
        room = (cnt_d < DEPTH_C);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
            buf_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= StIdle;
            fetch_pc_q    <= RESET_ADDR[31:2];
            inflight_pc_q <= '0;
            req_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_q <= StReq;
                    req_q   <= room;
                    busy_q  <= 1'b0;
                end
                StReq: begin
                    if (i_redirect) begin
                        fetch_pc_q <= i_redirect_pc;
                        if (fire) begin
                            state_q <= StDrop;
                            req_q   <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            req_q   <= room;
                            busy_q  <= 1'b0;
                        end
                    end else if (fire) begin
                        inflight_pc_q <= fetch_pc_q;
                        fetch_pc_q    <= fetch_pc_q + 30'd1;
                        state_q       <= StWait;
                        req_q         <= 1'b0;
                        busy_q        <= 1'b1;
                    end else begin
                        req_q  <= room;
                        busy_q <= 1'b0;
                    end
                end
                StWait: begin
                    if (i_redirect) begin
                        fetch_pc_q <= i_redirect_pc;
                        if (i_imem_rvalid) begin
                            state_q <= StReq;
                            req_q   <= room;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= StDrop;
                            req_q   <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end else if (i_imem_rvalid) begin
                        busy_q <= 1'b0;
                        if (i_imem_err) begin
                            state_q <= StHalt;
                            req_q   <= 1'b0;
                        end else begin
                            state_q <= StReq;
                            req_q   <= room;
                        end
                    end
                end
                StDrop: begin
                    // A response landing in the redirect cycle is the one being dropped.
                    if (i_redirect) begin
                        fetch_pc_q <= i_redirect_pc;
                    end
                    if (i_imem_rvalid) begin
                        state_q <= StReq;
                        req_q   <= room;
                        busy_q  <= 1'b0;
                    end
                end
                StHalt: begin
                    if (i_redirect) begin
                        fetch_pc_q <= i_redirect_pc;
                        state_q    <= StReq;
                        req_q      <= room;
                    end
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req   = req_q;
    assign o_imem_addr  = fetch_pc_q;
    assign o_busy       = busy_q;
    assign o_inst_valid = (cnt_q != '0);
    assign o_inst       = buf_q[0].inst;
    assign o_inst_pc    = buf_q[0].pc;
    assign o_inst_err   = (cnt_q != '0) && buf_q[0].err;

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Scoreboard bench for rv_fetch_ctrl: directed scenarios push expected requests and
// instructions; a monitor pops and compares on every bus grant and decode handshake.
module tb_rv_fetch_ctrl;

`ifdef RV_FETCH_CTRL_SKID_EN
    localparam int EXP_DEPTH = 2;
`else
    localparam int EXP_DEPTH = 1;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_redirect;
    logic [31:2] i_redirect_pc;
    logic        i_dec_ready;
    logic        o_imem_req;
    logic [31:2] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_imem_err;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:2] o_inst_pc;
    logic        o_inst_err;
    logic        o_busy;

    always #5 i_clk = ~i_clk;

    rv_fetch_ctrl #(.RESET_ADDR(32'h0000_0000)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_dec_ready   (i_dec_ready),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_imem_err    (i_imem_err),
        .o_inst_valid  (o_inst_valid),
        .o_inst        (o_inst),
        .o_inst_pc     (o_inst_pc),
        .o_inst_err    (o_inst_err),
        .o_busy        (o_busy)
    );

    typedef struct {
        logic [31:2] pc;
        logic        err;
    } exp_t;

    exp_t        exp_inst[$];
    logic [31:2] exp_req[$];
    int          checks = 0;
    int          errors = 0;
    int          n_gnt  = 0;

    bit          gnt_en;
    bit          err_on;
    bit          pend;
    logic [31:2] err_at;
    logic [31:2] pend_addr;

    function automatic logic [31:0] data_of(input logic [31:2] pc);
        return {pc, 2'b01} ^ 32'hC3A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus model: grants per gnt_en, answers exactly one cycle after a grant.
    task automatic tick();
        i_imem_rvalid = pend;
        i_imem_rdata  = pend ? data_of(pend_addr) : 32'h0;
        i_imem_err    = pend && err_on && (pend_addr == err_at);
        i_imem_gnt    = gnt_en;
        pend          = o_imem_req && gnt_en && !i_reset;
        pend_addr     = o_imem_addr;
        @(negedge i_clk);
    endtask

    task automatic push_inst(input logic [31:2] pc, input logic err);
        exp_t e;
        e.pc  = pc;
        e.err = err;
        exp_inst.push_back(e);
    endtask

    task automatic do_reset();
        i_reset     = 1'b1;
        i_redirect  = 1'b0;
        i_dec_ready = 1'b1;
        gnt_en      = 1'b1;
        err_on      = 1'b0;
        tick();
        tick();
        exp_inst.delete();
        exp_req.delete();
        check("rst_req", 32'(o_imem_req), 32'd0);
        check("rst_addr", 32'(o_imem_addr), 32'd0);
        check("rst_valid", 32'(o_inst_valid), 32'd0);
        check("rst_err", 32'(o_inst_err), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        i_reset = 1'b0;
    endtask

    task automatic wait_req_at(input logic [31:2] addr);
        int n = 0;
        while (!(o_imem_req && o_imem_addr == addr) && n < 60) begin
            tick();
            n++;
        end
        check("wait_req", 32'(o_imem_req && (o_imem_addr == addr)), 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_inst.size() != 0 && n < 80) begin
            tick();
            n++;
        end
        check({name, "_inst_left"}, 32'(exp_inst.size()), 32'd0);
        check({name, "_req_left"}, 32'(exp_req.size()), 32'd0);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:2] a;
        forever begin
            @(negedge i_clk);
            #2;
            if (!i_reset && o_imem_req && i_imem_gnt) begin
                n_gnt++;
                if (exp_req.size() > 0) begin
                    a = exp_req.pop_front();
                    check("req_addr", 32'(o_imem_addr), 32'(a));
                end
            end
            if (!i_reset && o_inst_valid && i_dec_ready) begin
                if (exp_inst.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst: got pc %h, expected none", o_inst_pc);
                end else begin
                    e = exp_inst.pop_front();
                    check("inst_pc", 32'(o_inst_pc), 32'(e.pc));
                    check("inst_err", 32'(o_inst_err), 32'(e.err));
                    check("inst_data", o_inst, data_of(e.pc));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int g0;
        i_reset       = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_dec_ready   = 1'b1;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = '0;
        i_imem_err    = 1'b0;
        gnt_en        = 1'b1;
        err_on        = 1'b0;
        err_at        = '0;
        pend          = 1'b0;
        pend_addr     = '0;
        @(negedge i_clk);

        // Sequential fetch from reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_req.push_back(30'(i));
            push_inst(30'(i), 1'b0);
        end
        drain("seq");

        // Redirect in the grant cycle of addr 5.
        do_reset();
        for (int i = 0; i < 6; i++) exp_req.push_back(30'(i));
        for (int i = 0; i < 5; i++) push_inst(30'(i), 1'b0);
        wait_req_at(30'd5);
        i_redirect    = 1'b1;
        i_redirect_pc = 30'h100;
        tick();
        i_redirect = 1'b0;
        check("drop_busy", 32'(o_busy), 32'd1);
        check("drop_flush", 32'(o_inst_valid), 32'd0);
        exp_req.push_back(30'h100);
        exp_req.push_back(30'h101);
        push_inst(30'h100, 1'b0);
        push_inst(30'h101, 1'b0);
        tick();
        check("drop_done_busy", 32'(o_busy), 32'd0);
        check("drop_next_addr", 32'(o_imem_addr), 32'h100);
        drain("redir");

        // Bus error halts fetch until redirect.
        do_reset();
        err_on = 1'b1;
        err_at = 30'd3;
        for (int i = 0; i < 4; i++) exp_req.push_back(30'(i));
        for (int i = 0; i < 3; i++) push_inst(30'(i), 1'b0);
        push_inst(30'd3, 1'b1);
        drain("err");
        repeat (5) begin
            tick();
            check("halt_no_req", 32'(o_imem_req), 32'd0);
        end
        i_redirect    = 1'b1;
        i_redirect_pc = 30'h40;
        tick();
        i_redirect = 1'b0;
        err_on     = 1'b0;
        exp_req.push_back(30'h40);
        push_inst(30'h40, 1'b0);
        drain("halt_redir");

        // Decode stall fills the buffer, then drains in order.
        do_reset();
        i_dec_ready = 1'b0;
        g0 = n_gnt;
        exp_req.push_back(30'd0);
`ifdef RV_FETCH_CTRL_SKID_EN
        exp_req.push_back(30'd1);
`endif
        repeat (14) tick();
        check("stall_grants", 32'(n_gnt - g0), 32'(EXP_DEPTH));
        check("stall_req", 32'(o_imem_req), 32'd0);
        check("stall_valid", 32'(o_inst_valid), 32'd1);
        check("stall_head_pc", 32'(o_inst_pc), 32'd0);
        check("stall_busy", 32'(o_busy), 32'd0);
        for (int i = 0; i < 3; i++) push_inst(30'(i), 1'b0);
        i_dec_ready = 1'b1;
        drain("stall");

        // Reset while a response arrives.
        do_reset();
        for (int i = 0; i < 3; i++) exp_req.push_back(30'(i));
        push_inst(30'd0, 1'b0);
        push_inst(30'd1, 1'b0);
        wait_req_at(30'd2);
        tick();
        check("mid_busy", 32'(o_busy), 32'd1);
        i_reset = 1'b1;
        tick();
        check("mid_rst_req", 32'(o_imem_req), 32'd0);
        check("mid_rst_valid", 32'(o_inst_valid), 32'd0);
        check("mid_rst_err", 32'(o_inst_err), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_addr", 32'(o_imem_addr), 32'd0);
        i_reset = 1'b0;
        exp_req.push_back(30'd0);
        push_inst(30'd0, 1'b0);
        drain("mid_rst");

        // Redirect concurrent with a response in WAIT.
        do_reset();
        for (int i = 0; i < 3; i++) exp_req.push_back(30'(i));
        push_inst(30'd0, 1'b0);
        push_inst(30'd1, 1'b0);
        wait_req_at(30'd2);
        tick();
        i_redirect    = 1'b1;
        i_redirect_pc = 30'h80;
        tick();
        i_redirect = 1'b0;
        check("wr_busy", 32'(o_busy), 32'd0);
        check("wr_valid", 32'(o_inst_valid), 32'd0);
        check("wr_req", 32'(o_imem_req), 32'd1);
        check("wr_addr", 32'(o_imem_addr), 32'h80);
        exp_req.push_back(30'h80);
        push_inst(30'h80, 1'b0);
        drain("wait_redir");

        // Address wrap, with an ungranted redirect first.
        do_reset();
        gnt_en = 1'b0;
        tick();
        i_redirect    = 1'b1;
        i_redirect_pc = 30'h3FFF_FFFF;
        tick();
        i_redirect = 1'b0;
        check("nogrant_addr", 32'(o_imem_addr), 32'h3FFF_FFFF);
        check("nogrant_req", 32'(o_imem_req), 32'd1);
        gnt_en = 1'b1;
        exp_req.push_back(30'h3FFF_FFFF);
        tick();
        check("wrap_addr", 32'(o_imem_addr), 32'd0);
        check("wrap_busy", 32'(o_busy), 32'd1);
        exp_req.push_back(30'd0);
        push_inst(30'h3FFF_FFFF, 1'b0);
        push_inst(30'd0, 1'b0);
        drain("wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
